// File: rtl/sync_fifo_prog.sv
// sync_fifo_prog: single-clock FIFO with programmable almost flags, sticky errors, flush and optional FWFT read
module sync_fifo_prog #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16,
  parameter bit FWFT = 1'b0,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             i_flush,
  input  logic             i_wren,
  input  logic [WIDTH-1:0] i_wrdata,
  input  logic             i_rden,
  input  logic [AW:0]      i_afull_thr,
  input  logic [AW:0]      i_aempty_thr,
  input  logic             i_clr_err,
  output logic [WIDTH-1:0] o_rddata,
  output logic             o_rdvalid,
  output logic             o_full,
  output logic             o_empty,
  output logic             o_alm_full,
  output logic             o_alm_empty,
  output logic [AW:0]      o_count,
  output logic             o_ovf,
  output logic             o_udf
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] count;
  logic [WIDTH-1:0] rd_q;
  logic rv_q;
  logic wr_acc, rd_acc;
  always_comb begin
    o_full = count == (AW+1)'(DEPTH);
    o_empty = count == '0;
    o_alm_full = count >= i_afull_thr;
    o_alm_empty = count <= i_aempty_thr;
    o_count = count;
    wr_acc = i_wren & ~o_full;
    rd_acc = i_rden & ~o_empty;
    o_rddata = FWFT ? mem[rd_ptr] : rd_q;
    o_rdvalid = FWFT ? ~o_empty : rv_q;
  end
  always_ff @(posedge clk)
    if (rstn && !i_flush && wr_acc) mem[wr_ptr] <= i_wrdata;
  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      rd_q <= '0;
      rv_q <= 1'b0;
      o_ovf <= 1'b0;
      o_udf <= 1'b0;
    end else if (i_flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      rv_q <= 1'b0;
    end else begin
      wr_ptr <= wr_ptr + AW'(wr_acc);
      rd_ptr <= rd_ptr + AW'(rd_acc);
      count <= count + (AW+1)'(wr_acc) - (AW+1)'(rd_acc);
      rv_q <= rd_acc;
      if (rd_acc) rd_q <= mem[rd_ptr];
      o_ovf <= (i_wren & o_full) | (o_ovf & ~i_clr_err);
      o_udf <= (i_rden & o_empty) | (o_udf & ~i_clr_err);
    end
  end
endmodule

// File: tb/tb_sync_fifo_prog.sv
// tb_sync_fifo_prog: standard and FWFT instances on shared stimulus, checked against a queue model
module tb_sync_fifo_prog;
  logic clk = 0, rstn = 0, flush = 0, wren = 0, rden = 0, clr_err = 0;
  logic [31:0] wrdata = 0;
  logic [4:0] afull_thr = 14, aempty_thr = 2;
  logic [31:0] s_rddata, f_rddata;
  logic s_rdvalid, s_full, s_empty, s_alm_full, s_alm_empty, s_ovf, s_udf;
  logic f_rdvalid, f_full, f_empty, f_alm_full, f_alm_empty, f_ovf, f_udf;
  logic [4:0] s_count, f_count;
  logic [6:0] s_flags;
  int total = 0, bad = 0;
  logic [31:0] q[$];
  logic m_ovf = 0, m_udf = 0, e_rv = 0;
  logic [31:0] e_rd = 0;

  always #5 clk = ~clk;
  assign s_flags = {s_full, s_empty, s_alm_full, s_alm_empty, s_ovf, s_udf, s_rdvalid};

  sync_fifo_prog #(.WIDTH(32), .DEPTH(16), .FWFT(1'b0)) u_std (
    .clk(clk), .rstn(rstn), .i_flush(flush), .i_wren(wren), .i_wrdata(wrdata), .i_rden(rden),
    .i_afull_thr(afull_thr), .i_aempty_thr(aempty_thr), .i_clr_err(clr_err),
    .o_rddata(s_rddata), .o_rdvalid(s_rdvalid), .o_full(s_full), .o_empty(s_empty),
    .o_alm_full(s_alm_full), .o_alm_empty(s_alm_empty), .o_count(s_count), .o_ovf(s_ovf), .o_udf(s_udf));

  sync_fifo_prog #(.WIDTH(32), .DEPTH(16), .FWFT(1'b1)) u_fw (
    .clk(clk), .rstn(rstn), .i_flush(flush), .i_wren(wren), .i_wrdata(wrdata), .i_rden(rden),
    .i_afull_thr(afull_thr), .i_aempty_thr(aempty_thr), .i_clr_err(clr_err),
    .o_rddata(f_rddata), .o_rdvalid(f_rdvalid), .o_full(f_full), .o_empty(f_empty),
    .o_alm_full(f_alm_full), .o_alm_empty(f_alm_empty), .o_count(f_count), .o_ovf(f_ovf), .o_udf(f_udf));

  function automatic logic [6:0] exp_flags();
    int n = q.size();
    return {n == 16, n == 0, n >= int'(afull_thr), n <= int'(aempty_thr), m_ovf, m_udf, e_rv};
  endfunction

  task automatic tick();
    bit full, empty;
    @(posedge clk);
    if (!rstn) begin
      q.delete(); m_ovf = 0; m_udf = 0; e_rv = 0; e_rd = 0;
    end else if (flush) begin
      q.delete(); e_rv = 0;
    end else begin
      full = q.size() == 16;
      empty = q.size() == 0;
      m_ovf = (wren && full) || (m_ovf && !clr_err);
      m_udf = (rden && empty) || (m_udf && !clr_err);
      e_rv = 0;
      if (rden && !empty) begin e_rd = q.pop_front(); e_rv = 1; end
      if (wren && !full) q.push_back(wrdata);
    end
    #1;
  endtask

  task automatic idle();
    wren = 0; rden = 0; flush = 0; clr_err = 0;
  endtask

  task automatic test_reset();
    rstn = 0; idle(); tick(); tick();
    total++; if (s_flags !== 7'b0101000) begin bad++; $display("FAIL reset_flags got=%b want=%b", s_flags, 7'b0101000); end
    total++; if (s_count !== 0 || f_count !== 0) begin bad++; $display("FAIL reset_count got=%0d/%0d want=0", s_count, f_count); end
    total++; if (s_rddata !== 0 || f_rdvalid !== 0) begin bad++; $display("FAIL reset_rd got=%h/%b want=0/0", s_rddata, f_rdvalid); end
    rstn = 1; tick();
  endtask

  task automatic test_fill_drain();
    for (int i = 1; i <= 16; i++) begin wren = 1; wrdata = i; tick(); end
    idle();
    total++; if (s_full !== 1 || s_count !== 16) begin bad++; $display("FAIL fill_full got=%b/%0d want=1/16", s_full, s_count); end
    for (int i = 1; i <= 16; i++) begin
      rden = 1;
      total++; if (f_rdvalid !== 1 || f_rddata !== q[0]) begin bad++; $display("FAIL fwft_head got=%b/%h want=1/%h", f_rdvalid, f_rddata, q[0]); end
      tick();
      total++; if (s_rdvalid !== 1 || s_rddata !== e_rd || e_rd !== 32'(i)) begin bad++; $display("FAIL drain_data got=%b/%h want=1/%h", s_rdvalid, s_rddata, i); end
    end
    idle(); tick();
    total++; if (s_flags !== exp_flags() || s_empty !== 1) begin bad++; $display("FAIL drain_end got=%b want=%b", s_flags, exp_flags()); end
  endtask

  task automatic test_full_rw();
    for (int i = 0; i < 16; i++) begin wren = 1; wrdata = $urandom; tick(); end
    wren = 1; rden = 1; tick(); idle();
    total++; if (s_count !== 15 || s_ovf !== 1 || s_count !== 5'(q.size())) begin bad++; $display("FAIL full_rw got=%0d/%b want=15/1", s_count, s_ovf); end
    clr_err = 1; tick(); idle();
    total++; if (s_ovf !== 0 || f_ovf !== m_ovf) begin bad++; $display("FAIL clr_err got=%b/%b want=0", s_ovf, f_ovf); end
  endtask

  task automatic test_underflow();
    flush = 1; tick(); idle();
    rden = 1; tick(); idle();
    total++; if (s_udf !== 1 || s_rdvalid !== 0 || s_count !== 0) begin bad++; $display("FAIL udf got=%b/%b/%0d want=1/0/0", s_udf, s_rdvalid, s_count); end
    wren = 1; rden = 1; wrdata = 32'h1234; tick(); idle();
    total++; if (s_count !== 1 || s_flags !== exp_flags()) begin bad++; $display("FAIL empty_rw got=%0d/%b want=1/%b", s_count, s_flags, exp_flags()); end
    total++; if (f_rddata !== 32'h1234) begin bad++; $display("FAIL empty_rw_data got=%h want=1234", f_rddata); end
    clr_err = 1; tick(); idle();
  endtask

  task automatic test_thresholds();
    flush = 1; tick(); idle();
    afull_thr = 12; aempty_thr = 3;
    for (int n = 0; n <= 16; n++) begin
      if (n == 10) begin
        afull_thr = 8; #1;
        total++; if (s_alm_full !== 1) begin bad++; $display("FAIL thr_live got=%b want=1", s_alm_full); end
      end
      total++; if (s_alm_empty !== (n <= 3) || s_alm_full !== (n >= int'(afull_thr)) || s_count !== 5'(n)) begin
        bad++; $display("FAIL thr_n%0d got=%b/%b/%0d want=%b/%b/%0d", n, s_alm_empty, s_alm_full, s_count, n <= 3, n >= int'(afull_thr), n);
      end
      wren = (n < 16); wrdata = n; tick();
    end
    idle(); afull_thr = 14; aempty_thr = 2;
  endtask

  task automatic test_wrap();
    flush = 1; tick(); idle();
    for (int i = 0; i < 5; i++) begin wren = 1; wrdata = 32'h100 + i; tick(); end
    for (int i = 0; i < 40; i++) begin
      wren = 1; rden = 1; wrdata = $urandom; tick();
      total++; if (s_count !== 5 || s_rddata !== e_rd || s_rdvalid !== 1) begin bad++; $display("FAIL wrap_%0d got=%0d/%h want=5/%h", i, s_count, s_rddata, e_rd); end
    end
    idle(); tick();
  endtask

  task automatic test_flush();
    flush = 1; tick(); idle();
    for (int i = 0; i < 17; i++) begin wren = 1; wrdata = i; tick(); end
    flush = 1; wren = 0; tick(); idle();
    for (int i = 0; i < 7; i++) begin wren = 1; wrdata = i; tick(); end
    flush = 1; wren = 1; tick(); idle();
    total++; if (s_count !== 0 || s_empty !== 1 || s_ovf !== 1 || s_ovf !== m_ovf) begin bad++; $display("FAIL flush got=%0d/%b/%b want=0/1/1", s_count, s_empty, s_ovf); end
    total++; if (f_count !== 0 || f_rdvalid !== 0) begin bad++; $display("FAIL flush_fw got=%0d/%b want=0/0", f_count, f_rdvalid); end
    clr_err = 1; tick(); idle();
  endtask

  task automatic test_fwft_first();
    flush = 1; tick(); idle();
    wren = 1; wrdata = 32'hA5; tick(); idle();
    total++; if (f_rdvalid !== 1 || f_rddata !== 32'hA5) begin bad++; $display("FAIL fwft_first got=%b/%h want=1/a5", f_rdvalid, f_rddata); end
    tick();
    total++; if (f_rddata !== 32'hA5 || f_count !== 1 || s_rdvalid !== 0) begin bad++; $display("FAIL fwft_hold got=%h/%0d/%b want=a5/1/0", f_rddata, f_count, s_rdvalid); end
  endtask

  task automatic test_random();
    flush = 1; tick(); idle();
    for (int i = 0; i < 600; i++) begin
      int p = (i / 100) % 3 == 0 ? 80 : ((i / 100) % 3 == 1 ? 20 : 50);
      wren = $urandom_range(0, 99) < p;
      rden = $urandom_range(0, 99) < 100 - p;
      wrdata = $urandom;
      clr_err = $urandom_range(0, 31) == 0;
      flush = $urandom_range(0, 127) == 0;
      if ($urandom_range(0, 15) == 0) begin afull_thr = $urandom_range(0, 16); aempty_thr = $urandom_range(0, 16); end
      tick();
      total++; if (s_flags !== exp_flags() || s_count !== 5'(q.size()) || f_count !== 5'(q.size())) begin
        bad++; $display("FAIL rand_%0d flags got=%b/%0d want=%b/%0d", i, s_flags, s_count, exp_flags(), q.size());
      end
      total++; if ((e_rv && s_rddata !== e_rd) || f_rdvalid !== (q.size() != 0) || (q.size() != 0 && f_rddata !== q[0])) begin
        bad++; $display("FAIL rand_%0d data got=%h/%h want=%h", i, s_rddata, f_rddata, e_rd);
      end
    end
    idle(); afull_thr = 14; aempty_thr = 2;
  endtask

  task automatic test_mid_reset();
    for (int i = 0; i < 6; i++) begin wren = 1; wrdata = i + 7; tick(); end
    wren = 1; rden = 1; wrdata = 32'hDEAD; rstn = 0; tick();
    total++; if (s_flags !== 7'b0101000 || s_count !== 0 || s_rddata !== 0) begin bad++; $display("FAIL mid_reset got=%b/%0d/%h want=0101000/0/0", s_flags, s_count, s_rddata); end
    total++; if (f_rdvalid !== 0 || f_count !== 0 || f_ovf !== 0) begin bad++; $display("FAIL mid_reset_fw got=%b/%0d want=0/0", f_rdvalid, f_count); end
    idle(); rstn = 1; tick();
    total++; if (s_rdvalid !== 0 || s_flags !== exp_flags()) begin bad++; $display("FAIL post_reset got=%b want=%b", s_flags, exp_flags()); end
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_full_rw();
    test_underflow();
    test_thresholds();
    test_wrap();
    test_flush();
    test_fwft_first();
    test_random();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
